instr_fetch: RTL and testbench

//  Instruction-fetch stage: owns the program counter and drives the instruction-memory request.

---
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues same-cycle instruction-memory requests and
// holds the fetched word with its PC in a one-entry buffer for decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_idx,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCOut,
    output logic [31:0] instr,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StFull
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_out_q;
    logic [31:0] instr_q;
    logic        valid_q;

    logic [31:0] pc_plus4;
    logic [31:0] pc_tgt;
    logic        accept;
    logic [1:0]  unused_jr_low;

    // Register-jump targets are forced word-aligned.
    assign unused_jr_low = jr_addr[1:0];

    // Redirect targets are relative to the buffered instruction, not to pc_q.
    always_comb begin
        pc_plus4 = pc_out_q + 32'd4;
        pc_tgt   = pc_plus4;
        unique case (pc_sel)
            2'b00: pc_tgt = pc_plus4;
            2'b01: pc_tgt = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
            2'b10: pc_tgt = {pc_plus4[31:28], jump_idx, 2'b00};
            2'b11: pc_tgt = {jr_addr[31:2], 2'b00};
            default: pc_tgt = pc_plus4;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        unique case (state_q)
            StBoot:  imem_req = 1'b0;
            StFetch: imem_req = !redirect;
            StFull:  imem_req = !stall && !redirect;
            default: imem_req = 1'b0;
        endcase
    end

    assign accept = imem_req && imem_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StBoot;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q <= StFetch;
                end
                StFetch, StFull: begin
                    if (redirect) begin
                        pc_q    <= pc_tgt;
                        valid_q <= 1'b0;
                        state_q <= StFetch;
                    end else if (accept) begin
                        instr_q  <= imem_rdata;
                        pc_out_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        valid_q  <= 1'b1;
                        state_q  <= StFull;
                    end else if (state_q == StFull && !stall) begin
                        // Buffer consumed but no refill arrived.
                        valid_q <= 1'b0;
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign PCOut       = pc_out_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed per-cycle vector table for instr_fetch, followed by a randomized stall/ready
// sequence checking that no fetch address is skipped or duplicated.
module tb_instr_fetch;

    localparam logic [31:0] Key = 32'hC0DE_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic        redirect;
    logic [1:0]  pc_sel;
    logic [15:0] branch_imm;
    logic [25:0] jump_idx;
    logic [31:0] jr_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PCOut;
    logic [31:0] instr;
    logic        instr_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // Memory returns a word tagged with its own address.
    assign imem_rdata = imem_addr ^ Key;

    instr_fetch #(.RESET_PC(32'h0040_0000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .stall      (stall),
        .redirect   (redirect),
        .pc_sel     (pc_sel),
        .branch_imm (branch_imm),
        .jump_idx   (jump_idx),
        .jr_addr    (jr_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .PCOut      (PCOut),
        .instr      (instr),
        .instr_valid(instr_valid)
    );

    typedef struct {
        bit          pre;
        bit          rst;
        bit          stall;
        bit          redirect;
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] jr;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit pre, bit rst, bit stl, bit red, logic [1:0] sel,
                                logic [15:0] imm, logic [25:0] idx, logic [31:0] jr, bit rdy,
                                bit ereq, logic [31:0] eaddr, bit evalid, logic [31:0] epc);
        vec_t v;
        v.pre = pre; v.rst = rst; v.stall = stl; v.redirect = red; v.sel = sel;
        v.imm = imm; v.idx = idx; v.jr = jr; v.ready = rdy;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid; v.exp_pc = epc;
        return v;
    endfunction

    initial begin
        logic [31:0] last;
        logic [31:0] addr_s;
        bit          acc;

        RST = 1'b1; stall = 1'b0; redirect = 1'b0; pc_sel = 2'b00;
        branch_imm = '0; jump_idx = '0; jr_addr = '0; imem_ready = 1'b1;

        // Reset, boot bubble, then steady-state fetch.
        vecs.push_back(mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h0,        0, 32'h0040_0000));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h0040_0000, 0, 32'h0040_0000));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0040_0000, 1, 32'h0040_0000));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0040_0004, 1, 32'h0040_0004));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0040_0008, 1, 32'h0040_0008));
        // Stall three cycles in FULL, then release.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 32'h0040_000C, 1, 32'h0040_0008));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0040_000C, 1, 32'h0040_000C));
        // Memory not ready: drop to FETCH, hold address, then capture it.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h0040_0010, 0, 32'h0040_000C));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0040_0010, 1, 32'h0040_0010));
        // Backward branch with stall and ready also high.
        vecs.push_back(mk(1, 0, 1, 1, 2'b01, 16'hFFFE, 0, 0, 1, 0, 32'h0040_0014, 0, 32'h0040_0010));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h0040_000C, 0, 32'h0040_0010));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0040_000C, 1, 32'h0040_000C));
        // Get PCOut to 0x40000020 via jr (low bits dropped), then jump.
        vecs.push_back(mk(1, 0, 0, 1, 2'b11, 0, 0, 32'h4000_0022, 1, 0, 32'h0040_0010, 0,
                          32'h0040_000C));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h4000_0020, 1, 32'h4000_0020));
        vecs.push_back(mk(1, 0, 0, 1, 2'b10, 0, 26'h100, 0, 1, 0, 32'h4000_0024, 0,
                          32'h4000_0020));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h4000_0400, 0, 32'h4000_0020));
        vecs.push_back(mk(1, 0, 0, 1, 2'b11, 0, 0, 32'h1234_5677, 1, 0, 32'h4000_0400, 0,
                          32'h4000_0020));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h1234_5674, 0, 32'h4000_0020));
        // Address wrap at the top of memory.
        vecs.push_back(mk(1, 0, 0, 1, 2'b11, 0, 0, 32'hFFFF_FFF8, 0, 0, 32'h1234_5674, 0,
                          32'h4000_0020));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8));
        vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFF8));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0000_0000, 1, 32'h0000_0000));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0000_0004, 1, 32'h0000_0004));
        // Reset mid-stall with redirect asserted.
        vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 32'h0000_0008, 1, 32'h0000_0004));
        vecs.push_back(mk(1, 1, 1, 1, 2'b01, 16'h0004, 0, 0, 1, 0, 32'h0000_0008, 0,
                          32'h0040_0000));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h0040_0000, 0, 32'h0040_0000));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h0040_0000, 1, 32'h0040_0000));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            RST = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redirect;
            pc_sel = vecs[i].sel; branch_imm = vecs[i].imm; jump_idx = vecs[i].idx;
            jr_addr = vecs[i].jr; imem_ready = vecs[i].ready;
            #1;
            if (vecs[i].pre) begin
                chk($sformatf("row%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
                chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
            end
            @(posedge CLK);
            #1;
            chk($sformatf("row%0d instr_valid", i), {31'd0, instr_valid},
                {31'd0, vecs[i].exp_valid});
            chk($sformatf("row%0d PCOut", i), PCOut, vecs[i].exp_pc);
            if (vecs[i].rst)
                chk($sformatf("row%0d instr", i), instr, 32'd0);
            else if (vecs[i].exp_valid)
                chk($sformatf("row%0d instr", i), instr, vecs[i].exp_pc ^ Key);
        end

        // Random stall/ready mix: fetches must stay strictly sequential.
        last = 32'h0040_0000;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            RST = 1'b0; redirect = 1'b0;
            stall = 1'($urandom_range(0, 1));
            imem_ready = 1'($urandom_range(0, 2) != 0);
            #1;
            acc = imem_req && imem_ready;
            addr_s = imem_addr;
            chk($sformatf("rnd%0d imem_addr", c), addr_s, last + 32'd4);
            @(posedge CLK);
            #1;
            if (acc) begin
                last = last + 32'd4;
                chk($sformatf("rnd%0d instr_valid", c), {31'd0, instr_valid}, 32'd1);
                chk($sformatf("rnd%0d instr", c), instr, last ^ Key);
            end
            chk($sformatf("rnd%0d PCOut", c), PCOut, last);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
